factorial_inverse: RTL and testbench
====================================

// Module: factorial_inverse
// PURPOSE
//  Inverse of the factorial engine. Given a value x, it finds the largest n with n! <= x.
//  It also flags whether x is exactly n!.
//  Computes k! incrementally, using repeated-addition multiplication (no multiplier).
//  Sits beside the factorial engine: verifies its results, or decodes a factorial code to its index.
// PARAMETERS
//  WIDTH        32  operand width of x and of the internal products
//  NBITS        5   width of n_out (must hold the max n with n! < 2^WIDTH; 12 at WIDTH=32)
//  SYNC_STAGES  2   flip-flop stages on the asynchronous go_btn input
// PORTS
//  clk     in   1       single clock, rising edge
//  rst     in   1       synchronous, active-high reset
//  go_btn  in   1       asynchronous start button, synchronized internally
//  x       in   WIDTH   value to invert; sampled on the accepted start cycle
//  busy    out  1       high while a computation is in progress
//  done    out  1       high from completion until the next accepted start
//  exact   out  1       x == n_out! (valid while done)
//  n_out   out  NBITS   largest n with n! <= x (valid while done)
// BEHAVIOUR
//  Reset: all outputs are 0 and the FSM is in IDLE.
//   Synchronizer flops and the edge-detect history are cleared.
//   Reset mid-computation aborts immediately; no done pulse follows.
//  Start: go_btn passes through SYNC_STAGES flops, then a rising-edge detect.
//   A start is accepted only in IDLE or DONE. A level held high gives exactly one start.
//   Edges seen while busy are dropped, not queued.
//  FSM states: IDLE, LOAD, CHECK, MULT, FIN.
//  IDLE/DONE -> LOAD on an accepted start:
//   latch xr = x; clear done and exact; set busy = 1.
//  LOAD -> FIN if xr == 0: n_out = 0, exact = 0.
//  LOAD -> CHECK otherwise: prod = 1, k = 1.
//  CHECK -> MULT: acc = prod, cnt = k.
//   MULT forms prod*(k+1) as prod plus k further additions of prod, one addition per cycle.
//   acc is WIDTH+1 bits, with a sticky overflow bit ovf.
//   MULT exits early when acc > xr or ovf is set.
//  MULT end, when acc > xr or ovf: -> FIN with n_out = k and exact = (prod == xr).
//  MULT end otherwise: prod = acc, k = k+1, -> CHECK.
//  FIN: busy = 0, done = 1, then the FSM holds in the DONE condition (waits in IDLE with done set).
//  Latency:
//   x=0: 3 cycles from the accepted edge to done.
//   Otherwise: sum over steps of (k+2) cycles, plus 3. Below 110 cycles at WIDTH=32.
//  Width rule: k never exceeds 2^NBITS-1. Overflow ends the search before k can wrap.
//  x = 1 reports n_out = 1 (largest n, not 0), exact = 1.
//  Outputs are registered. n_out and exact change only in FIN or on reset.
// STRUCTURE
//  factorial_pkg (shared with the factorial engine):
//   state enum typedef;
//   WIDTH default;
//   MAX_N localparam (12) and the FACT_MAX constant 32'd479001600.
//  Sub-module btn_sync: SYNC_STAGES-deep 2FF chain plus a rising-edge pulse output.
//   The forward engine reuses btn_sync for its go and rst_btn inputs.
//  The top level holds the FSM, the acc/prod/k/cnt registers and the compare logic.
// TESTING
//  x=120, pulse go_btn -> done=1, n_out=5, exact=1, busy low on the same cycle done rises.
//  x=121 -> n_out=5, exact=0.
//  x=0 -> done within 3 cycles of the sync edge, n_out=0, exact=0.
//  x=1 -> n_out=1, exact=1.
//  x=2 -> n_out=2, exact=1.
//  x=479001600 -> n_out=12, exact=1.
//  x=32'hFFFF_FFFF -> n_out=12, exact=0, with no wrap of k or acc.
//  Hold go_btn high 50 cycles, and toggle it mid-computation -> exactly one result.
//   n_out is unchanged until a new edge after done.
//  Assert rst in a MULT cycle with x=479001600 -> next cycle busy=0, done=0, n_out=0.
//   A fresh go with x=6 then gives n_out=3, exact=1.
//  Back-to-back: done for x=24, then go with x=720 -> done drops on the accepted start.
//   Then n_out=6, exact=1.

Source files
------------

// File: rtl/factorial_pkg.sv
// factorial_pkg
//   Shared definitions for the factorial engine and its inverse.
//   state_e   : sequencing states of the inverse search FSM
//   WIDTH_DEF : default operand width
//   MAX_N     : largest n whose factorial fits in WIDTH_DEF bits
//   FACT_MAX  : MAX_N! at WIDTH_DEF = 32
package factorial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_MULT  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int          WIDTH_DEF = 32;
  localparam int          MAX_N     = 12;
  localparam logic [31:0] FACT_MAX  = 32'd479001600;

endpackage

// File: rtl/factorial_inverse_btn_sync.sv
// btn_sync
//   Synchronizes an asynchronous button through SYNC_STAGES flops and emits a
//   one-cycle pulse on each rising edge of the synchronized level.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the chain and edge history
//   btn   : asynchronous button level
//   level : synchronized button level
//   rise  : one-cycle pulse on a rising edge of level
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/factorial_inverse.sv
// factorial_inverse
//   Finds the largest n with n! <= x and flags whether x == n!. Factorials are
//   built incrementally; each multiply by (k+1) is k repeated additions.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   go_btn : asynchronous start button
//   x      : value to invert, sampled on the accepted start
//   busy   : computation in progress
//   done   : result valid, held until the next accepted start
//   exact  : x == n_out!
//   n_out  : largest n with n! <= x
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a start; done set here once a result exists
// ST_LOAD  | x latched; zero short-cuts to FIN, else prod=1, k=1
// ST_CHECK | seed acc = prod, cnt = k for the next multiply
// ST_MULT  | one addition of prod per cycle; exits when acc passes xr
// ST_FIN   | publish n_out/exact, drop busy, raise done
module factorial_inverse
  import factorial_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int NBITS       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_btn,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic             exact,
  output logic [NBITS-1:0] n_out
);

  logic go_level;
  logic go_rise;

  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_go_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (go_btn),
    .level (go_level),
    .rise  (go_rise)
  );

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   xr_q, xr_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [NBITS-1:0]   k_q, k_d;
  logic [NBITS-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               exact_q, exact_d;
  logic [NBITS-1:0]   n_out_q, n_out_d;

  // One extra bit above acc so a carry out of acc can latch ovf.
  logic [WIDTH+1:0]   sum;
  logic               acc_past;

  assign sum      = {1'b0, acc_q} + {2'b00, prod_q};
  assign acc_past = (acc_q > {1'b0, xr_q}) || ovf_q;

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    exact_d = exact_q;
    n_out_d = n_out_q;

    case (state_q)
      ST_IDLE: begin
        if (go_rise) begin
          xr_d    = x;
          done_d  = 1'b0;
          exact_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // prod=1 keeps exact false for x=0 when FIN compares prod to xr.
        prod_d = {{(WIDTH-1){1'b0}}, 1'b1};
        if (xr_q == '0) begin
          k_d     = '0;
          state_d = ST_FIN;
        end else begin
          k_d     = {{(NBITS-1){1'b0}}, 1'b1};
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        acc_d   = {1'b0, prod_q};
        cnt_d   = k_q;
        ovf_d   = 1'b0;
        state_d = ST_MULT;
      end
      ST_MULT: begin
        if (acc_past) begin
          state_d = ST_FIN;
        end else if (cnt_q == '0) begin
          // acc <= xr here, so it fits in WIDTH bits.
          prod_d  = acc_q[WIDTH-1:0];
          k_d     = k_q + 1'b1;
          state_d = ST_CHECK;
        end else begin
          acc_d = sum[WIDTH:0];
          ovf_d = ovf_q | sum[WIDTH+1];
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FIN: begin
        n_out_d = k_q;
        exact_d = (prod_q == xr_q);
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xr_q    <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exact_q <= 1'b0;
      n_out_q <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exact_q <= exact_d;
      n_out_q <= n_out_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign exact = exact_q;
  assign n_out = n_out_q;

  // The synchronized level itself is not needed; only its edge starts a run.
  logic unused_ok;
  assign unused_ok = go_level;

endmodule

// File: tb/tb_factorial_inverse.sv
module tb_factorial_inverse;
  import factorial_pkg::*;

  localparam int W = 32;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         go_btn;
  logic [W-1:0] x;
  logic         busy;
  logic         done;
  logic         exact;
  logic [N-1:0] n_out;

  int n_checks = 0;
  int n_fail   = 0;

  factorial_inverse #(.WIDTH(W), .NBITS(N), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .go_btn (go_btn),
    .x      (x),
    .busy   (busy),
    .done   (done),
    .exact  (exact),
    .n_out  (n_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Raise go and wait for the start to be accepted (busy high).
  task automatic start(input logic [W-1:0] xv, input string tag);
    int t;
    bit seen;
    x      = xv;
    go_btn = 1'b1;
    seen   = 0;
    for (t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    if (!seen) check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  // Wait for done, returning cycles counted after busy was first seen.
  task automatic wait_done(input string tag, output int lat);
    bit seen;
    lat  = 0;
    seen = 0;
    while (lat < 200 && !seen) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    if (!seen) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input logic [W-1:0] xv, input int exp_n, input bit exp_x, input string tag);
    int lat;
    start(xv, tag);
    go_btn = 1'b0;
    wait_done(tag, lat);
    check_eq({tag, "_n"},     32'(n_out), 32'(exp_n));
    check_eq({tag, "_exact"}, 32'(exact), 32'(exp_x));
    check_eq({tag, "_busy"},  32'(busy),  32'd0);
    idle_cycles(4);
  endtask

  initial begin
    int lat;
    int rises;
    bit prev_done;
    bit seen;

    rst    = 1'b1;
    go_btn = 1'b0;
    x      = '0;
    idle_cycles(3);
    check_eq("rst_busy",  32'(busy),  32'd0);
    check_eq("rst_done",  32'(done),  32'd0);
    check_eq("rst_exact", 32'(exact), 32'd0);
    check_eq("rst_n",     32'(n_out), 32'd0);
    rst = 1'b0;
    idle_cycles(3);

    run(32'd120, 5, 1'b1, "x120");
    run(32'd121, 5, 1'b0, "x121");

    // Zero: LOAD then FIN, done two cycles after busy is first seen.
    start(32'd0, "x0");
    go_btn = 1'b0;
    wait_done("x0", lat);
    check_eq("x0_lat",   32'(lat),   32'd2);
    check_eq("x0_n",     32'(n_out), 32'd0);
    check_eq("x0_exact", 32'(exact), 32'd0);
    idle_cycles(4);

    run(32'd1, 1, 1'b1, "x1");
    run(32'd2, 2, 1'b1, "x2");
    run(FACT_MAX, MAX_N, 1'b1, "xfmax");
    run(32'hFFFF_FFFF, MAX_N, 1'b0, "xffff");

    // Long hold with a mid-run toggle: only the first edge starts a run.
    x         = 32'd120;
    go_btn    = 1'b1;
    rises     = 0;
    prev_done = done;
    for (int i = 0; i < 50; i++) begin
      if (i == 8)  go_btn = 1'b0;
      if (i == 10) go_btn = 1'b1;
      @(negedge clk);
      if (done && !prev_done) rises++;
      prev_done = done;
    end
    check_eq("hold_rises", 32'(rises), 32'd1);
    check_eq("hold_n",     32'(n_out), 32'd5);
    x = 32'd6;
    idle_cycles(10);
    check_eq("hold_n_kept", 32'(n_out), 32'd5);
    check_eq("hold_done",   32'(done),  32'd1);
    go_btn = 1'b0;
    idle_cycles(4);

    // Reset during MULT aborts the run.
    start(FACT_MAX, "rstmid");
    go_btn = 1'b0;
    seen   = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (dut.state_q == ST_MULT) seen = 1;
    end
    check_eq("rstmid_in_mult", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_busy", 32'(busy),  32'd0);
    check_eq("rstmid_done", 32'(done),  32'd0);
    check_eq("rstmid_n",    32'(n_out), 32'd0);
    idle_cycles(3);
    run(32'd6, 3, 1'b1, "after_rst");

    // Back-to-back: done drops on the accepted start of the next run.
    run(32'd24, 4, 1'b1, "b2b_24");
    start(32'd720, "b2b_720");
    check_eq("b2b_done_drop", 32'(done), 32'd0);
    go_btn = 1'b0;
    wait_done("b2b_720", lat);
    check_eq("b2b_n",     32'(n_out), 32'd6);
    check_eq("b2b_exact", 32'(exact), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
